// File: rtl/fpu_muldiv_pkg.sv
// Shared types and constants for the single-precision multiply/divide
// post-normalisation path.
//   rmode_t  : IEEE rounding mode encoding carried with each op
//   op_t     : operation selector (multiply / divide)
//   QNAN     : canonical quiet NaN produced for any NaN result
//   EXP_W    : default width of the signed, biased pre-adjust exponent
//   BIAS     : single-precision exponent bias
//   MAXF     : mantissa field of the largest finite value
package fpu_muldiv_pkg;

    typedef enum logic [1:0] {
        RM_RNE  = 2'd0,
        RM_RTZ  = 2'd1,
        RM_PINF = 2'd2,
        RM_NINF = 2'd3
    } rmode_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_t;

    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam int          EXP_W    = 10;
    localparam int          BIAS     = 127;
    localparam logic [22:0] MAXF     = 23'h7FFFFF;
    localparam logic [7:0]  EXP_MAXF = 8'hFE;
    localparam logic [7:0]  EXP_INF  = 8'hFF;

endpackage

// File: rtl/round_pack_sp.sv
// Combinational rounding, range check and IEEE-754 packing for one
// normalised single-precision result.
//   man       in  24  normalised mantissa (man[23] is the hidden one)
//   g, s      in  1   guard and sticky bits below the mantissa
//   e         in  EW  signed biased exponent before rounding
//   sign      in  1   result sign
//   rmode     in  2   rounding mode
//   nan/inf/zero in 1 special-operand class, priority nan > inf > zero
//   word      out 32  packed result
//   inexact, overflow, underflow  out 1  exception flags
module round_pack_sp
    import fpu_muldiv_pkg::*;
#(
    parameter int EW = 11
) (
    input  logic [23:0]        man,
    input  logic               g,
    input  logic               s,
    input  logic signed [EW-1:0] e,
    input  logic               sign,
    input  rmode_t             rmode,
    input  logic               nan,
    input  logic               inf,
    input  logic               zero,
    output logic [31:0]        word,
    output logic               inexact,
    output logic               overflow,
    output logic               underflow
);

    localparam logic signed [EW:0]   E_OVF = (EW + 1)'(2 * BIAS + 1);
    localparam logic signed [EW:0]   E_ONE = (EW + 1)'(1);
    localparam logic signed [EW-1:0] E_MIN = '0;

    logic                up;
    logic                carry;
    logic [22:0]         man_r;
    logic signed [EW:0]  e_x;
    logic signed [EW:0]  e_r;
    logic                to_inf;

    always_comb begin
        up = 1'b0;
        case (rmode)
            RM_RNE:  up = g & (s | man[0]);
            RM_RTZ:  up = 1'b0;
            RM_PINF: up = (g | s) & ~sign;
            RM_NINF: up = (g | s) & sign;
            default: up = 1'b0;
        endcase

        // Carry out of the 24-bit mantissa only happens for all-ones; the
        // 23-bit fraction then wraps to zero, which is exactly 24'h800000.
        carry = up & (&man);
        man_r = man[22:0] + {22'b0, up};
        e_x   = {e[EW-1], e};
        e_r   = carry ? (e_x + E_ONE) : e_x;

        to_inf = (rmode == RM_RNE)
               | ((rmode == RM_PINF) & ~sign)
               | ((rmode == RM_NINF) & sign);

        word      = '0;
        inexact   = 1'b0;
        overflow  = 1'b0;
        underflow = 1'b0;

        if (nan) begin
            word = QNAN;
        end else if (inf) begin
            word = {sign, EXP_INF, 23'b0};
        end else if (zero) begin
            word = {sign, 31'b0};
        end else if (e <= E_MIN) begin
            word      = {sign, 31'b0};
            underflow = 1'b1;
            inexact   = 1'b1;
        end else if (e_r >= E_OVF) begin
            overflow = 1'b1;
            inexact  = 1'b1;
            word     = to_inf ? {sign, EXP_INF, 23'b0} : {sign, EXP_MAXF, MAXF};
        end else begin
            word    = {sign, e_r[7:0], man_r};
            inexact = g | s;
        end
    end

endmodule

// File: rtl/post_norm_muldiv.sv
// Post-normalisation, rounding and packing stage for single-precision
// multiply and divide. Issue-time sideband is delayed DATA_LAT cycles to
// meet the multiplier/divider data, normalised in stage 1, then rounded
// and packed in stage 2. One op per cycle, no backpressure.
//   clk, reset            clock, asynchronous active-high reset
//   iss_valid/op/rmode    op issued to the primitives this cycle
//   iss_sign, iss_exp     result sign and signed biased exponent
//   iss_nan/inf/zero      special-operand class from pre-normalisation
//   prod                  48-bit mantissa product (1.23 x 1.23)
//   quo, rem              50-bit quotient and remainder
//   out_valid, out        packed IEEE-754 result, T+DATA_LAT+2
//   inexact/overflow/underflow  exception flags, qualified by out_valid
module post_norm_muldiv #(
    parameter int DATA_LAT = 2,
    parameter int EXP_W    = fpu_muldiv_pkg::EXP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iss_valid,
    input  logic             iss_op,
    input  logic [1:0]       iss_rmode,
    input  logic             iss_sign,
    input  logic [EXP_W-1:0] iss_exp,
    input  logic             iss_nan,
    input  logic             iss_inf,
    input  logic             iss_zero,
    input  logic [47:0]      prod,
    input  logic [49:0]      quo,
    input  logic [49:0]      rem,
    output logic             out_valid,
    output logic [31:0]      out,
    output logic             inexact,
    output logic             overflow,
    output logic             underflow
);
    import fpu_muldiv_pkg::*;

    // One extra exponent bit so exp+1 / exp-1 never wraps.
    localparam int EW1 = EXP_W + 1;
    localparam logic signed [EW1-1:0] E_ONE = EW1'(1);

    typedef struct packed {
        logic                    valid;
        op_t                     op;
        rmode_t                  rmode;
        logic                    sign;
        logic [EXP_W-1:0]        exp;
        logic                    nan;
        logic                    inf;
        logic                    zero;
    } side_t;

    typedef struct packed {
        logic                    valid;
        rmode_t                  rmode;
        logic                    sign;
        logic                    nan;
        logic                    inf;
        logic                    zero;
        logic [23:0]             man;
        logic                    g;
        logic                    s;
        logic signed [EW1-1:0]   e;
    } norm_t;

    side_t iss_side;
    side_t dl [DATA_LAT];
    side_t head;
    norm_t n1;
    norm_t s1;

    logic        rem_nz;
    logic signed [EW1-1:0] e_ext;
    logic        unused_quo_hi;
    logic [31:0] rp_word;
    logic        rp_inexact;
    logic        rp_overflow;
    logic        rp_underflow;

    // Quotient bits above the 1.xx range never carry information.
    assign unused_quo_hi = ^quo[49:27];

    always_comb begin
        iss_side.valid = iss_valid;
        iss_side.op    = op_t'(iss_op);
        iss_side.rmode = rmode_t'(iss_rmode);
        iss_side.sign  = iss_sign;
        iss_side.exp   = iss_exp;
        iss_side.nan   = iss_nan;
        iss_side.inf   = iss_inf;
        iss_side.zero  = iss_zero;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < unsigned'(DATA_LAT); i++) begin
                dl[i] <= '0;
            end
        end else begin
            dl[0] <= iss_side;
            for (int unsigned i = 1; i < unsigned'(DATA_LAT); i++) begin
                dl[i] <= dl[i-1];
            end
        end
    end

    assign head = dl[DATA_LAT-1];

    // Stage 1: bring the mantissa to 1.23 and collect guard/sticky.
    always_comb begin
        rem_nz   = |rem;
        e_ext    = {head.exp[EXP_W-1], head.exp};
        n1.valid = head.valid;
        n1.rmode = head.rmode;
        n1.sign  = head.sign;
        n1.nan   = head.nan;
        n1.inf   = head.inf;
        n1.zero  = head.zero;
        n1.man   = prod[46:23];
        n1.g     = prod[22];
        n1.s     = |prod[21:0];
        n1.e     = e_ext;
        if (head.op == OP_MUL) begin
            if (prod[47]) begin
                n1.man = prod[47:24];
                n1.g   = prod[23];
                n1.s   = |prod[22:0];
                n1.e   = e_ext + E_ONE;
            end
        end else begin
            if (quo[26]) begin
                n1.man = quo[26:3];
                n1.g   = quo[2];
                n1.s   = (|quo[1:0]) | rem_nz;
                n1.e   = e_ext;
            end else begin
                n1.man = quo[25:2];
                n1.g   = quo[1];
                n1.s   = quo[0] | rem_nz;
                n1.e   = e_ext - E_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
        end else begin
            s1 <= n1;
        end
    end

    round_pack_sp #(
        .EW (EW1)
    ) u_round (
        .man       (s1.man),
        .g         (s1.g),
        .s         (s1.s),
        .e         (s1.e),
        .sign      (s1.sign),
        .rmode     (s1.rmode),
        .nan       (s1.nan),
        .inf       (s1.inf),
        .zero      (s1.zero),
        .word      (rp_word),
        .inexact   (rp_inexact),
        .overflow  (rp_overflow),
        .underflow (rp_underflow)
    );

    // Result and flags only move on valid lanes; bubbles leave them held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out       <= '0;
            inexact   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            out_valid <= s1.valid;
            if (s1.valid) begin
                out       <= rp_word;
                inexact   <= rp_inexact;
                overflow  <= rp_overflow;
                underflow <= rp_underflow;
            end
        end
    end

endmodule

// File: tb/tb_post_norm_muldiv.sv
// Directed self-checking bench for post_norm_muldiv.
module tb_post_norm_muldiv;
    import fpu_muldiv_pkg::*;

    localparam int LAT  = 2;
    localparam int EW   = 10;
    localparam int MAXV = 8;
    localparam int MAXC = MAXV + LAT + 6;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          iss_valid = 1'b0;
    logic          iss_op    = 1'b0;
    logic [1:0]    iss_rmode = '0;
    logic          iss_sign  = 1'b0;
    logic [EW-1:0] iss_exp   = '0;
    logic          iss_nan   = 1'b0;
    logic          iss_inf   = 1'b0;
    logic          iss_zero  = 1'b0;
    logic [47:0]   prod      = '0;
    logic [49:0]   quo       = '0;
    logic [49:0]   rem       = '0;
    logic          out_valid;
    logic [31:0]   out;
    logic          inexact;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic          valid;
        logic          op;
        logic [1:0]    rmode;
        logic          sign;
        logic [EW-1:0] exp;
        logic          nan;
        logic          inf;
        logic          zero;
        logic [47:0]   prod;
        logic [49:0]   quo;
        logic [49:0]   rem;
    } vec_t;

    vec_t        vq [MAXV];
    int          nv;
    logic        obs_v   [MAXC];
    logic [31:0] obs_out [MAXC];
    logic [2:0]  obs_f   [MAXC];

    post_norm_muldiv #(
        .DATA_LAT (LAT),
        .EXP_W    (EW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_op    (iss_op),
        .iss_rmode (iss_rmode),
        .iss_sign  (iss_sign),
        .iss_exp   (iss_exp),
        .iss_nan   (iss_nan),
        .iss_inf   (iss_inf),
        .iss_zero  (iss_zero),
        .prod      (prod),
        .quo       (quo),
        .rem       (rem),
        .out_valid (out_valid),
        .out       (out),
        .inexact   (inexact),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    function automatic vec_t blank();
        vec_t v;
        v.valid = 1'b0; v.op = 1'b0; v.rmode = 2'd0; v.sign = 1'b0;
        v.exp = '0; v.nan = 1'b0; v.inf = 1'b0; v.zero = 1'b0;
        v.prod = '0; v.quo = '0; v.rem = '0;
        return v;
    endfunction

    function automatic vec_t mk_mul(logic [1:0] rm, logic sg, logic [EW-1:0] ex, logic [47:0] p);
        vec_t v;
        v = blank();
        v.valid = 1'b1; v.op = 1'b0; v.rmode = rm; v.sign = sg; v.exp = ex; v.prod = p;
        return v;
    endfunction

    function automatic vec_t mk_div(logic [1:0] rm, logic sg, logic [EW-1:0] ex, logic [49:0] q, logic [49:0] r);
        vec_t v;
        v = blank();
        v.valid = 1'b1; v.op = 1'b1; v.rmode = rm; v.sign = sg; v.exp = ex; v.quo = q; v.rem = r;
        return v;
    endfunction

    // Specials carry an exponent/product that would overflow if not overridden.
    function automatic vec_t mk_spec(logic n, logic i, logic z, logic sg);
        vec_t v;
        v = mk_mul(2'd0, sg, 10'd254, 48'h900000000000);
        v.nan = n; v.inf = i; v.zero = z;
        return v;
    endfunction

    task automatic drive_iss(input vec_t v);
        iss_valid = v.valid; iss_op = v.op; iss_rmode = v.rmode; iss_sign = v.sign;
        iss_exp = v.exp; iss_nan = v.nan; iss_inf = v.inf; iss_zero = v.zero;
    endtask

    task automatic drive_data(input vec_t v);
        prod = v.prod; quo = v.quo; rem = v.rem;
    endtask

    // Issues vq[0..nv-1] on consecutive cycles, feeds data LAT cycles later,
    // and records outputs mid-cycle; op i is expected at obs index i+LAT+2.
    task automatic run_ops();
        for (int c = 0; c < MAXC; c++) begin
            @(negedge clk);
            obs_v[c]   = out_valid;
            obs_out[c] = out;
            obs_f[c]   = {inexact, overflow, underflow};
            if (c < nv) drive_iss(vq[c]);
            else        drive_iss(blank());
            if (c >= LAT && c - LAT < nv) drive_data(vq[c-LAT]);
            else                          drive_data(blank());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else passed++;
        checks++;
        if ({out, inexact, overflow, underflow} !== 35'd0)
            $display("FAIL reset_out: got %h/%b%b%b expected 0", out, inexact, overflow, underflow);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_idle_valid: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic test_mul_basic();
        nv = 1;
        vq[0] = mk_mul(2'd0, 1'b0, 10'd127, 48'h900000000000);
        run_ops();
        checks++;
        if (obs_v[LAT+1] !== 1'b0) $display("FAIL mul_early_valid: got %b expected 0", obs_v[LAT+1]); else passed++;
        checks++;
        if (obs_v[LAT+2] !== 1'b1) $display("FAIL mul_valid: got %b expected 1", obs_v[LAT+2]); else passed++;
        checks++;
        if (obs_out[LAT+2] !== 32'h40100000) $display("FAIL mul_out: got %h expected 40100000", obs_out[LAT+2]); else passed++;
        checks++;
        if (obs_f[LAT+2] !== 3'b000) $display("FAIL mul_flags: got %b expected 000", obs_f[LAT+2]); else passed++;
        checks++;
        if (obs_v[LAT+3] !== 1'b0) $display("FAIL mul_late_valid: got %b expected 0", obs_v[LAT+3]); else passed++;
    endtask

    task automatic test_div_round();
        logic [49:0] dvd, dvs, q3, r3, q15, r15;
        logic [31:0] ew [5];
        logic [2:0]  ef [5];
        dvd = 50'(24'h800000) << 26; dvs = 50'(24'hC00000);
        q3  = dvd / dvs; r3 = dvd % dvs;
        dvd = 50'(24'hC00000) << 26; dvs = 50'(24'h800000);
        q15 = dvd / dvs; r15 = dvd % dvs;
        nv = 5;
        vq[0] = mk_div(2'd0, 1'b0, 10'd126, q3, r3);
        vq[1] = mk_div(2'd1, 1'b0, 10'd126, q3, r3);
        vq[2] = mk_div(2'd2, 1'b0, 10'd126, q3, r3);
        vq[3] = mk_div(2'd3, 1'b1, 10'd126, q3, r3);
        vq[4] = mk_div(2'd0, 1'b0, 10'd127, q15, r15);
        ew = '{32'h3EAAAAAB, 32'h3EAAAAAA, 32'h3EAAAAAB, 32'hBEAAAAAB, 32'h3FC00000};
        ef = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b000};
        run_ops();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs_v[i+LAT+2] !== 1'b1) $display("FAIL div_valid[%0d]: got %b expected 1", i, obs_v[i+LAT+2]); else passed++;
            checks++;
            if (obs_out[i+LAT+2] !== ew[i]) $display("FAIL div_out[%0d]: got %h expected %h", i, obs_out[i+LAT+2], ew[i]); else passed++;
            checks++;
            if (obs_f[i+LAT+2] !== ef[i]) $display("FAIL div_flags[%0d]: got %b expected %b", i, obs_f[i+LAT+2], ef[i]); else passed++;
        end
    endtask

    task automatic test_overflow();
        logic [31:0] ew [4];
        nv = 4;
        vq[0] = mk_mul(2'd0, 1'b0, 10'd254, 48'h900000000000);
        vq[1] = mk_mul(2'd1, 1'b0, 10'd254, 48'h900000000000);
        vq[2] = mk_mul(2'd2, 1'b1, 10'd254, 48'h900000000000);
        vq[3] = mk_mul(2'd3, 1'b1, 10'd254, 48'h900000000000);
        ew = '{32'h7F800000, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'hFF800000};
        run_ops();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_out[i+LAT+2] !== ew[i]) $display("FAIL ovf_out[%0d]: got %h expected %h", i, obs_out[i+LAT+2], ew[i]); else passed++;
            checks++;
            if (obs_f[i+LAT+2] !== 3'b110) $display("FAIL ovf_flags[%0d]: got %b expected 110", i, obs_f[i+LAT+2]); else passed++;
        end
    endtask

    task automatic test_underflow();
        logic [31:0] ew [4];
        logic [2:0]  ef [4];
        nv = 4;
        vq[0] = mk_mul(2'd0, 1'b0, 10'd0, 48'h400000000000);
        vq[1] = mk_mul(2'd0, 1'b1, 10'd0, 48'h400000000000);
        vq[2] = mk_mul(2'd0, 1'b0, 10'd1, 48'h400000000000);
        vq[3] = mk_mul(2'd0, 1'b0, 10'd0, 48'h900000000000);
        ew = '{32'h00000000, 32'h80000000, 32'h00800000, 32'h00900000};
        ef = '{3'b101, 3'b101, 3'b000, 3'b000};
        run_ops();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_out[i+LAT+2] !== ew[i]) $display("FAIL unf_out[%0d]: got %h expected %h", i, obs_out[i+LAT+2], ew[i]); else passed++;
            checks++;
            if (obs_f[i+LAT+2] !== ef[i]) $display("FAIL unf_flags[%0d]: got %b expected %b", i, obs_f[i+LAT+2], ef[i]); else passed++;
        end
    endtask

    task automatic test_rollover();
        logic [31:0] ew [2];
        nv = 2;
        vq[0] = mk_mul(2'd0, 1'b0, 10'd126, 48'h7FFFFFC00000);
        vq[1] = mk_mul(2'd1, 1'b0, 10'd126, 48'h7FFFFFC00000);
        ew = '{32'h3F800000, 32'h3F7FFFFF};
        run_ops();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_out[i+LAT+2] !== ew[i]) $display("FAIL roll_out[%0d]: got %h expected %h", i, obs_out[i+LAT+2], ew[i]); else passed++;
            checks++;
            if (obs_f[i+LAT+2] !== 3'b100) $display("FAIL roll_flags[%0d]: got %b expected 100", i, obs_f[i+LAT+2]); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ew [6];
        int nvalid;
        nv = 6;
        vq[0] = mk_spec(1'b1, 1'b0, 1'b0, 1'b0);
        vq[1] = mk_spec(1'b0, 1'b1, 1'b0, 1'b1);
        vq[2] = mk_spec(1'b0, 1'b0, 1'b1, 1'b0);
        vq[3] = mk_mul(2'd0, 1'b0, 10'd127, 48'h900000000000);
        vq[4] = mk_spec(1'b1, 1'b1, 1'b1, 1'b1);
        vq[5] = mk_spec(1'b0, 1'b1, 1'b1, 1'b0);
        ew = '{32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h40100000, 32'h7FC00000, 32'h7F800000};
        run_ops();
        nvalid = 0;
        for (int c = 0; c < MAXC; c++) if (obs_v[c] === 1'b1) nvalid++;
        checks++;
        if (nvalid != 6) $display("FAIL b2b_valid_count: got %0d expected 6", nvalid); else passed++;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs_out[i+LAT+2] !== ew[i]) $display("FAIL b2b_out[%0d]: got %h expected %h", i, obs_out[i+LAT+2], ew[i]); else passed++;
            checks++;
            if (obs_f[i+LAT+2] !== 3'b000) $display("FAIL b2b_flags[%0d]: got %b expected 000", i, obs_f[i+LAT+2]); else passed++;
        end
    endtask

    task automatic test_reset_inflight();
        vec_t a, b;
        a = mk_mul(2'd0, 1'b0, 10'd127, 48'h900000000000);
        b = mk_mul(2'd0, 1'b1, 10'd127, 48'h400000000000);
        @(negedge clk); drive_iss(a); drive_data(blank());
        @(negedge clk); drive_iss(b);
        @(negedge clk); drive_iss(blank()); drive_data(a);
        @(negedge clk); drive_data(b);
        @(negedge clk); drive_data(blank());
        checks++;
        if (out_valid !== 1'b1 || out !== 32'h40100000)
            $display("FAIL rst_pre: got %b/%h expected 1/40100000", out_valid, out);
        else passed++;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL rst_async_valid: got %b expected 0", out_valid); else passed++;
        checks++;
        if ({out, inexact, overflow, underflow} !== 35'd0)
            $display("FAIL rst_async_out: got %h/%b%b%b expected 0", out, inexact, overflow, underflow);
        else passed++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 1) reset = 1'b0;
            checks++;
            if (out_valid !== 1'b0) $display("FAIL rst_hold_valid[%0d]: got %b expected 0", k, out_valid); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_div_round();
        test_overflow();
        test_underflow();
        test_rollover();
        test_back_to_back();
        test_reset_inflight();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
